// File: rtl/master_control_fsm_if.sv
// Handshake bundle between the game sequencer and its surroundings:
// button and score inputs, plus the mode/score/countdown outputs for the VGA stage.
interface master_control_fsm_if;
  logic       BTN_START;
  logic       SCORE_EVENT;
  logic [1:0] MASTER_CONTROL;
  logic [3:0] SCORE;
  logic [5:0] SECONDS_LEFT;

  modport slave (
    input  BTN_START,
    input  SCORE_EVENT,
    output MASTER_CONTROL,
    output SCORE,
    output SECONDS_LEFT
  );

  modport master (
    output BTN_START,
    output SCORE_EVENT,
    input  MASTER_CONTROL,
    input  SCORE,
    input  SECONDS_LEFT
  );
endinterface

// File: rtl/master_control_fsm.sv
// Game/mode sequencer: debounces the start button, runs the countdown and score,
// and drives the registered 2-bit mode word consumed by the VGA colour stage.
module master_control_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICKS_PER_SEC   = 100000000,
  parameter int unsigned GAME_SECONDS    = 30,
  parameter int unsigned TARGET_SCORE    = 3
) (
  input logic                 CLK,
  input logic                 RESETn,
  master_control_fsm_if.slave bus
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  // A zero-second game would underflow the countdown, so it is promoted to one second.
  localparam logic [5:0] SECS_INIT = (GAME_SECONDS == 0) ? 6'd1 : 6'(GAME_SECONDS);
  localparam logic [3:0] SCORE_WIN = 4'(TARGET_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_level_q, db_level_d;
  logic              db_prev_q, db_prev_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  state_t            state_q, state_d;
  logic [3:0]        score_q, score_d;
  logic [5:0]        secs_q, secs_d;

  logic       start_pulse;
  logic       tick_wrap;
  logic [3:0] score_inc;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      tick_q     <= '0;
      state_q    <= ST_IDLE;
      score_q    <= 4'd0;
      secs_q     <= SECS_INIT;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_prev_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      score_q    <= score_d;
      secs_q     <= secs_d;
    end
  end

  // The counter only runs while the synchronised button disagrees with the
  // debounced level, so any disagreement shorter than DEBOUNCE_CYCLES is lost.
  always_comb begin
    sync1_d    = bus.BTN_START;
    sync2_d    = sync1_q;
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    db_prev_d  = db_level_q;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign start_pulse = db_level_q & ~db_prev_q;
  assign tick_wrap   = (tick_q == TICK_LAST);
  assign score_inc   = (score_q == 4'hF) ? 4'hF : score_q + 4'd1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    secs_d  = secs_q;
    tick_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d = ST_PLAY;
          score_d = 4'd0;
          secs_d  = SECS_INIT;
        end
      end
      ST_PLAY: begin
        tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
        if (tick_wrap && (secs_q != 6'd0)) begin
          secs_d = secs_q - 6'd1;
        end
        if (bus.SCORE_EVENT) begin
          score_d = score_inc;
        end
        // A point landing on the final tick still counts, and winning beats losing.
        if (bus.SCORE_EVENT && (score_inc == SCORE_WIN)) begin
          state_d = ST_WIN;
        end else if (tick_wrap && (secs_q == 6'd1)) begin
          state_d = ST_LOSE;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_pulse) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.MASTER_CONTROL = state_q;
  assign bus.SCORE          = score_q;
  assign bus.SECONDS_LEFT   = secs_q;

endmodule
